// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder step per clock, LSB first.
// Result and carry-out are published together on the edge entering DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic             carry_q, carry_d, co_q, co_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sum_bit, carry_nxt;

  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        carry_d = c;
        res_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // last bit: publish the completed word straight from the shifter input
          s_d     = {sum_bit, res_q[WIDTH-1:1]};
          co_d    = carry_nxt;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder; a sum-level model predicts
// busy/done timing and the published result every cycle.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         c = 1'b0;
  logic         busy, done, co;
  logic [W-1:0] s;

  int checks = 0, errors = 0, done_cnt = 0;
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .s(s), .co(co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted request yields {co,s} = a+b+c after W busy cycles,
  // followed by one done cycle and one idle cycle.
  int         run_left = 0;
  bit         in_done  = 1'b0;
  logic [W:0] pend = '0;
  logic [W-1:0] exp_s = '0;
  bit         exp_co = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      run_left = 0; in_done = 1'b0; exp_s = '0; exp_co = 1'b0;
    end else if (in_done) begin
      in_done = 1'b0;
    end else if (run_left > 0) begin
      run_left--;
      if (run_left == 0) begin
        in_done = 1'b1;
        {exp_co, exp_s} = pend;
      end
    end else if (start) begin
      pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      run_left = W;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, run_left > 0);
      chk("done", done, in_done);
      chk("s",    s,    exp_s);
      chk("co",   co,   exp_co);
      if (done) done_cnt++;
    end
  end

  // Called at a negedge while idle; returns at the idle negedge after DONE.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        output int lat, output int busy_n, output logic [W-1:0] rs,
                        output logic rco, output bit held);
    logic [W-1:0] s0;
    logic         co0;
    s0 = s; co0 = co; held = 1'b1;
    a = ia; b = ib; c = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (s !== s0 || co !== co0) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("done_timeout", done, 1'b1);
    rs = s; rco = co;
    @(negedge clk);
  endtask

  int lat, bn, d0, tcnt;
  logic [W-1:0] rs;
  logic rco;
  bit held;
  int t[3];

  initial begin
    // reset for two edges
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_s", s, 8'h00);
    chk("rst_co", co, 1'b0);
    chk_en = 1'b1;

    // 00+00+1
    run_op(8'h00, 8'h00, 1'b1, lat, bn, rs, rco, held);
    chk("lat", lat, W + 1);
    chk("busy_cycles", bn, W);
    chk("s_001", rs, 8'h01);
    chk("co_001", rco, 1'b0);

    // wrap, then hold of the previous result across the next run
    run_op(8'hFF, 8'h01, 1'b0, lat, bn, rs, rco, held);
    chk("s_ff01", rs, 8'h00);
    chk("co_ff01", rco, 1'b1);
    run_op(8'h3C, 8'hC3, 1'b0, lat, bn, rs, rco, held);
    chk("s_3cc3", rs, 8'hFF);
    chk("co_3cc3", rco, 1'b0);
    chk("held_during_run", held, 1'b1);

    // start pulsed mid-run must be ignored
    a = 8'h96; b = 8'h78; c = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    for (int k = 1; k <= 30; k++) begin
      start = (k == 3);
      if (k == 3) begin a = 8'h01; b = 8'h01; end
      if (done) begin rs = s; rco = co; end
      @(negedge clk);
    end
    chk("s_9678", rs, 8'h0E);
    chk("co_9678", rco, 1'b1);
    chk("one_done", done_cnt - d0, 1);

    // reset aborts a run in its fourth cycle
    a = 8'hFF; b = 8'hFF; c = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    for (int k = 1; k <= 20; k++) begin
      rst = (k == 4);
      if (k == 5) begin
        chk("abort_busy", busy, 1'b0);
        chk("abort_s", s, 8'h00);
        chk("abort_co", co, 1'b0);
      end
      @(negedge clk);
    end
    chk("abort_no_done", done_cnt - d0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, lat, bn, rs, rco, held);
    chk("s_after_abort", rs, 8'hFF);
    chk("co_after_abort", rco, 1'b1);

    // start held high: back-to-back operations, operands changing every cycle
    start = 1'b1;
    tcnt = 0;
    for (int k = 0; k < 80 && tcnt < 3; k++) begin
      if (done) begin t[tcnt] = k; tcnt++; end
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_three_dones", tcnt, 3);
    if (tcnt == 3) begin
      chk("spacing_0", t[1] - t[0], W + 2);
      chk("spacing_1", t[2] - t[1], W + 2);
    end

    // random traffic with occasional resets
    d0 = done_cnt;
    for (int k = 0; k < 1500; k++) begin
      start = ($urandom_range(3) == 0);
      rst   = ($urandom_range(99) == 0);
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (W + 3) @(negedge clk);
    checks++;
    if (done_cnt - d0 < 20) begin
      errors++;
      $display("FAIL random_dones actual=%0d expected>=20", done_cnt - d0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
